mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter for the single shared memory port. Requester 0 is instruction fetch; requester 1 is load/store.
- Drives the select of the 32-bit 2:1 muxes that steer address, write data and control onto the port, and sequences one transaction at a time.
- Enforces a bounded wait on memory ready. A hung access terminates with an error instead of stalling the pipeline forever.

Parameters:
TIMEOUT, 16, max BUSY cycles waiting for mem_ready_i before abort; legal range 2..255
CNT_W, 8, width of wait counter; must satisfy 2**CNT_W > TIMEOUT

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous reset, active-high
req0_i  input  1  fetch request; held high until done0_o
req1_i  input  1  load/store request; held high until done1_o
gnt0_o  output  1  port owned by requester 0 (high for whole BUSY)
gnt1_o  output  1  port owned by requester 1 (high for whole BUSY)
sel_o  output  1  mux select: 0 = requester 0 path, 1 = requester 1 path
mem_req_o  output  1  transaction valid to memory
mem_ready_i  input  1  memory completes current transaction this cycle
done0_o  output  1  one-cycle completion pulse to requester 0
done1_o  output  1  one-cycle completion pulse to requester 1
err_o  output  1  one-cycle pulse coincident with done*_o when the transaction timed out

Behaviour:
- Reset (rst_i high at a clock edge):
  - state = IDLE; all outputs 0.
  - last_owner = 1, so requester 0 wins the first tie.
  - wait_cnt = 0.
  - Reset mid-transaction abandons it silently: no done, no err.
- State IDLE:
  - mem_req_o = 0; gnt* = 0.
  - sel_o holds its last value so the muxes do not toggle.
- IDLE transition, sampled at edge N:
  - Only req0 → owner = 0.
  - Only req1 → owner = 1.
  - Both → owner = ~last_owner.
  - Neither → stay IDLE.
  - On a grant: state = BUSY; from cycle N+1, sel_o = owner, gnt_owner = 1, mem_req_o = 1, wait_cnt = 0.
- State BUSY:
  - sel_o, gnt*, mem_req_o are stable and unaffected by req*_i changes.
  - The non-owner request is ignored until the next IDLE.
- Completion, mem_ready_i high at edge M:
  - done_owner = 1 and err_o = 0 in cycle M+1.
  - last_owner = owner; state = IDLE; mem_req_o, gnt* = 0 in cycle M+1.
- Timeout:
  - Each BUSY cycle without mem_ready_i increments wait_cnt.
  - When wait_cnt == TIMEOUT-1 and mem_ready_i is low: done_owner = 1 and err_o = 1 next cycle; last_owner updated; state = IDLE.
  - mem_ready_i high in the same cycle as the timeout → normal completion; ready wins, err_o = 0.
- Throughput:
  - Minimum transaction is 1 BUSY cycle plus 1 IDLE cycle, so at most one grant per 2 cycles.
  - Back-to-back requests from both sides alternate owners strictly.
- Request deasserted while BUSY → the transaction still completes and done still pulses; the requester must tolerate this.
- done0_o and done1_o are never high together; gnt0_o and gnt1_o are never high together.
- mem_ready_i while IDLE is ignored.

Decomposition:
- Shared package:
  - state enum {IDLE, BUSY}.
  - Owner encoding constants OWN_IF = 1'b0, OWN_LS = 1'b1, reused by the mux select wiring.
  - Default TIMEOUT constant.
- One natural sub-module: rr_pick2, combinational; inputs req0, req1, last_owner; outputs valid and owner.
- FSM and timeout counter stay in the top level.
- The datapath muxes stay outside the block, driven by sel_o.

Test Plan:
1. After reset, req0=1 only, mem_ready_i=1 on 3rd BUSY cycle → gnt0_o/mem_req_o high 3 cycles, sel_o=0, done0_o pulses 1 cycle, err_o=0.
2. req0=req1=1 held, mem_ready_i tied 1 → owners alternate 0,1,0,1; sel_o tracks the owner; one done per 2 cycles.
3. Owner 1 active, req0 rises mid-BUSY → sel_o stays 1 until done1_o; owner 0 granted the following IDLE cycle.
4. TIMEOUT=16, mem_ready_i held 0 → done*_o and err_o pulse after exactly 16 BUSY cycles; mem_req_o drops the same cycle.
5. mem_ready_i asserted exactly on the 16th BUSY cycle → done pulses with err_o=0.
6. rst_i asserted in the 2nd BUSY cycle → next cycle all outputs 0, no done/err; a subsequent tie grants requester 0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
// No logic; referenced by the arbiter top and its round-robin picker.
// Owner encodings double as the datapath mux select values.
package mem_port_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Owner encodings; also the value placed on the datapath mux select.
    localparam logic OWN_IF = 1'b0;  // instruction fetch
    localparam logic OWN_LS = 1'b1;  // load/store

    localparam int DEFAULT_TIMEOUT = 16;
    localparam int DEFAULT_CNT_W   = 8;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: chooses the owner of the next transaction.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_owner,
    output logic o_valid,
    output logic o_owner
);

    // On a tie the requester that did not own the port last time wins.
    always_comb begin
        o_valid = i_req0 | i_req1;
        o_owner = OWN_IF;
        if (i_req0 && i_req1) begin
            o_owner = ~i_last_owner;
        end else if (i_req1) begin
            o_owner = OWN_LS;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the shared memory port; one transaction at a time.
// Latency: grant 1 cycle after request sample; done/err 1 cycle after ready or timeout.
// Backpressure: waits on mem_ready_i for at most TIMEOUT BUSY cycles, then aborts with err_o.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o,
    output logic sel_o,
    output logic mem_req_o,
    input  logic mem_ready_i,
    output logic done0_o,
    output logic done1_o,
    output logic err_o
);

    // Count value reached on the final permitted BUSY cycle.
    localparam logic [CNT_W-1:0] L_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e           r_state;
    logic             r_owner;
    logic             r_last_owner;
    logic             r_sel;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_done0;
    logic             r_done1;
    logic             r_err;

    state_e           w_state_nxt;
    logic             w_owner_nxt;
    logic             w_last_owner_nxt;
    logic             w_sel_nxt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic             w_done0_nxt;
    logic             w_done1_nxt;
    logic             w_err_nxt;

    logic             w_pick_vld;
    logic             w_pick_owner;
    logic             w_cnt_last;

    rr_pick2 u_pick (
        .i_req0       (req0_i),
        .i_req1       (req1_i),
        .i_last_owner (r_last_owner),
        .o_valid      (w_pick_vld),
        .o_owner      (w_pick_owner)
    );

    assign w_cnt_last = (r_wait_cnt == L_CNT_LAST);

    // Next-state logic: grant from IDLE, finish on ready or on the wait limit.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_sel_nxt        = r_sel;
        w_wait_cnt_nxt   = r_wait_cnt;
        w_done0_nxt      = 1'b0;
        w_done1_nxt      = 1'b0;
        w_err_nxt        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt    = BUSY;
                    w_owner_nxt    = w_pick_owner;
                    w_sel_nxt      = w_pick_owner;
                    w_wait_cnt_nxt = '0;
                end
            end
            BUSY: begin
                if (mem_ready_i || w_cnt_last) begin
                    // Ready takes priority over a coincident timeout.
                    w_state_nxt      = IDLE;
                    w_last_owner_nxt = r_owner;
                    w_done0_nxt      = (r_owner == OWN_IF);
                    w_done1_nxt      = (r_owner == OWN_LS);
                    w_err_nxt        = ~mem_ready_i;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset drops any transaction in flight without a done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_owner      <= OWN_IF;
            r_last_owner <= OWN_LS;
            r_sel        <= OWN_IF;
            r_wait_cnt   <= '0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_sel        <= w_sel_nxt;
            r_wait_cnt   <= w_wait_cnt_nxt;
            r_done0      <= w_done0_nxt;
            r_done1      <= w_done1_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign mem_req_o = (r_state == BUSY);
    assign gnt0_o    = (r_state == BUSY) && (r_owner == OWN_IF);
    assign gnt1_o    = (r_state == BUSY) && (r_owner == OWN_LS);
    assign sel_o     = r_sel;
    assign done0_o   = r_done0;
    assign done1_o   = r_done1;
    assign err_o     = r_err;

endmodule
